// File: rtl/wb_efuse_shadow_loader.sv
// Wishbone classic-cycle initiator that copies NUM_WORDS eFuse words into a shadow bank.
// Each word is a separate cycle followed by one idle GAP cycle. A per-word timeout
// abandons the word, keeps its old shadow value and flags the first failing index.
module wb_efuse_shadow_loader #(
  parameter int unsigned NUM_WORDS      = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  output logic [31:0]               wbm_adr_o,
  output logic [31:0]               wbm_dat_o,
  input  logic [31:0]               wbm_dat_i,
  output logic                      wbm_we_o,
  output logic [3:0]                wbm_sel_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_cyc_o,
  input  logic                      wbm_ack_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [3:0]                err_idx_o,
  output logic [32*NUM_WORDS-1:0]   shadow_o
);

  localparam logic [3:0]  LastIdx     = 4'(NUM_WORDS - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [3:0]  err_idx_q, err_idx_d;
  logic        auto_q, auto_d;
  logic        cap;
  logic        go;
  logic [31:0] shadow_q [NUM_WORDS];

  // Next-state, status bookkeeping and Wishbone outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    auto_d    = auto_q;
    cap       = 1'b0;
    go        = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = 32'h0;
    wbm_we_o  = 1'b0;
    wbm_dat_o = 32'h0;

    unique case (state_q)
      StIdle: go = start_i | auto_q;
      StReq: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = BASE_ADDR + {26'h0, idx_q, 2'b00};
        cnt_d     = cnt_q + 16'd1;
        // Ack wins over a timeout landing on the same cycle.
        if (wbm_ack_i) begin
          cap     = 1'b1;
          state_d = StGap;
        end else if (cnt_q == TimeoutLast) begin
          if (!err_q) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
          state_d = StGap;
        end
      end
      StGap: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = 16'd0;
          state_d = StReq;
        end
      end
      StDone: go = start_i;
      default: state_d = StIdle;
    endcase

    if (go) begin
      state_d   = StReq;
      auto_d    = 1'b0;
      idx_d     = 4'd0;
      cnt_d     = 16'd0;
      err_d     = 1'b0;
      err_idx_d = 4'd0;
    end
  end

  assign busy_o    = (state_q == StReq) || (state_q == StGap);
  assign done_o    = (state_q == StDone);
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;

  // Control state registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
      err_idx_q <= 4'd0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      auto_q    <= auto_d;
    end
  end

  // Shadow bank: one word captured per acknowledged cycle.
  always_ff @(posedge wb_clk_i) begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (wb_rst_i) begin
        shadow_q[k] <= 32'h0;
      end else if (cap && (idx_q == 4'(k))) begin
        shadow_q[k] <= wbm_dat_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_shadow
    assign shadow_o[32*g +: 32] = shadow_q[g];
  end

endmodule
